// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the E-stage decoder.
//   - op-code encodings for the 3-bit op field
//   - default busy durations for multiply and divide
//   - FSM state encoding
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
//
// The result is computed when the request is accepted and parked in a
// single 64-bit result register; it is committed to hi/lo on the edge
// where busy falls. The busy window only models the pipeline latency.
//
// State table:
//   IDLE | no operation in flight, accepts start
//   RUN  | operation in flight, cnt counts down to commit
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   one-cycle request strobe
//   op      in   [2:0] op code (see mdu_pkg)
//   rs_val  in   [31:0] first operand
//   rt_val  in   [31:0] second operand
//   busy    out  high while an operation is in flight
//   hi      out  [31:0] HI register
//   lo      out  [31:0] LO register
//
// Build option: define MDU_MADD_EN to enable op 7 (MADD,
// {hi,lo} += signed product). Without it op 7 is ignored like NONE.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   hi_d, lo_d;
  logic [63:0]   res, res_d;
  logic          dz, dz_d;   // divide by zero: run the latency, skip the commit
`ifdef MDU_MADD_EN
  logic          madd_q, madd_d;
`endif

  // Multipliers: low 64 bits of the extended operands give the exact product.
  logic [63:0] smul, umul;
  assign smul = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign umul = {32'b0, rs_val} * {32'b0, rt_val};

  // Divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // instead of overflowing a signed divider.
  logic        neg_a, neg_b, div0;
  logic [31:0] mag_a, mag_b, mq, mr, squo, srem, uquo, urem;
  assign div0  = (rt_val == 32'd0);
  assign neg_a = rs_val[31];
  assign neg_b = rt_val[31];
  assign mag_a = neg_a ? (32'd0 - rs_val) : rs_val;
  assign mag_b = neg_b ? (32'd0 - rt_val) : rt_val;
  assign mq    = div0 ? 32'd0 : (mag_a / mag_b);
  assign mr    = div0 ? 32'd0 : (mag_a % mag_b);
  assign squo  = (neg_a ^ neg_b) ? (32'd0 - mq) : mq;
  assign srem  = neg_a ? (32'd0 - mr) : mr;
  assign uquo  = div0 ? 32'd0 : (rs_val / rt_val);
  assign urem  = div0 ? 32'd0 : (rs_val % rt_val);

  assign busy = (state == RUN);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi;
    lo_d    = lo;
    res_d   = res;
    dz_d    = dz;
`ifdef MDU_MADD_EN
    madd_d  = madd_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              res_d   = (op == OP_MULT) ? smul : umul;
              dz_d    = 1'b0;
              state_d = RUN;
              cnt_d   = CW'(MULT_CYCLES);
`ifdef MDU_MADD_EN
              madd_d  = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
              res_d   = (op == OP_DIV) ? {srem, squo} : {urem, uquo};
              dz_d    = div0;
              state_d = RUN;
              cnt_d   = CW'(DIV_CYCLES);
`ifdef MDU_MADD_EN
              madd_d  = 1'b0;
`endif
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
              res_d   = smul;
              dz_d    = 1'b0;
              state_d = RUN;
              cnt_d   = CW'(MULT_CYCLES);
              madd_d  = 1'b1;
            end
`endif
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!dz) begin
`ifdef MDU_MADD_EN
            if (madd_q) {hi_d, lo_d} = {hi, lo} + res;
            else        {hi_d, lo_d} = res;
`else
            {hi_d, lo_d} = res;
`endif
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res    <= '0;
      dz     <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      hi     <= hi_d;
      lo     <= lo_d;
      res    <= res_d;
      dz     <= dz_d;
`ifdef MDU_MADD_EN
      madd_q <= madd_d;
`endif
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for multiply operations.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for divide operations.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage request strobe; valid for one cycle.
REQ-006 op  input  3  operation code.
REQ-007 rs_val  input  32  first operand.
REQ-008 rt_val  input  32  second operand.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.

Function
REQ-012 Op codes SHALL be: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
REQ-013 start with op NONE, or with op 7 when the MADD feature is compiled out, SHALL be ignored.
REQ-014 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored. The E stage stalls on busy||start.
REQ-015 FSM states SHALL be IDLE and RUN, with counter cnt.
REQ-016 Transition IDLE->RUN on an accepted MULT, MULTU, DIV, DIVU or MADD. cnt loads MULT_CYCLES or DIV_CYCLES.
REQ-017 In RUN, cnt SHALL decrement each cycle. When cnt reaches 1, the state SHALL move RUN->IDLE and hi/lo SHALL be written on that edge.
REQ-018 busy SHALL equal (state==RUN). For an accepted start at edge T, busy SHALL be high for exactly N cycles starting after edge T, and hi/lo SHALL be updated on the edge where busy falls.
REQ-019 Operands SHALL be latched at the accepted start. Later changes to rs_val/rt_val SHALL have no effect.
REQ-020 MULT: {hi,lo} SHALL be the signed 64-bit product. MULTU: {hi,lo} SHALL be the unsigned 64-bit product.
REQ-021 DIV: lo SHALL be the signed quotient truncated toward zero, and hi SHALL be the remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
REQ-022 DIV/DIVU with rt_val=0 SHALL still run DIV_CYCLES with busy high, and hi/lo SHALL remain unchanged.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-024 MTHI/MTLO SHALL write hi/lo from rs_val on the next edge, with no busy cycle.
REQ-025 hi/lo SHALL hold their values at all times other than REQ-017, REQ-024 and reset.

Reset
REQ-026 Reset SHALL force state=IDLE, cnt=0, busy=0, hi=0, lo=0 on the next edge.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset asserted during RUN SHALL abort the operation with no hi/lo commit.

Configuration
REQ-029 Macro MDU_MADD_EN SHALL control the MADD operation.
REQ-030 With MDU_MADD_EN defined, op 7 (MADD) SHALL run MULT_CYCLES, then set {hi,lo} to {hi,lo} + signed(rs_val*rt_val), modulo 2^64. The {hi,lo} addend is sampled at commit.
REQ-031 With MDU_MADD_EN undefined, op 7 SHALL behave as NONE, and no MADD adder SHALL be synthesised.

Structure
REQ-032 Op-code localparams and the default cycle counts SHALL reside in shared package mdu_pkg, also used by the decoder.
REQ-033 The block SHALL contain no sub-modules. Sign handling and a single 64-bit result register SHALL be inline.

Verification
REQ-034 MULT rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-035 MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 MTLO 0x1234 then DIVU rs=5, rt=0 -> busy 10 cycles; lo=0x1234, hi=0 after completion.
REQ-038 MULT 3*4, MTHI 0xAA issued at busy cycle 2 -> MTHI ignored; final hi=0, lo=0xC.
REQ-039 MTLO 7, DIV started, reset at busy cycle 4 -> next cycle busy=0, hi=0, lo=0; no later commit.
